hex_display_slave: RTL and testbench
====================================

// Module: hex_display_slave
// PURPOSE
//  Avalon-MM slave peripheral inside dnn_accel_system that owns all six seven-segment displays.
//  Software writes a 24-bit value plus control bits; the block decodes 6 hex nibbles to active-low segments.
//  Supports per-digit enable, leading-zero blanking and a programmable blink.
//  Replaces the single hex_export path so HEX0..HEX5 are all driven from one register map.
// PARAMETERS
//  BLINK_DIV_RST  25_000_000  reset value of BLINK_DIV reg (cycles per blink half-period; 0.5 s @ 50 MHz)
//  CNT_W          32          width of blink counter and BLINK_DIV reg
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  address     in   2   Avalon word address (0 VALUE, 1 CTRL, 2 BLINK_DIV, 3 STATUS)
//  read        in   1   Avalon read strobe
//  write       in   1   Avalon write strobe
//  writedata   in   32  Avalon write data
//  readdata    out  32  Avalon read data, fixed read latency 1
//  hex0..hex5  out  7   segment drives, active low, bit0=seg a .. bit6=seg g; hex0 = nibble [3:0]
// BEHAVIOUR
//  Reset (sync): VALUE=0, CTRL=0x03F, BLINK_DIV=BLINK_DIV_RST, blink cnt=0, phase=0, readdata=0, hex*=7'h7F.
//  Registers:
//   VALUE[23:0] RW; bits [31:24] read 0, writes ignored.
//   CTRL RW: [5:0] digit enable (digit i shown only if bit i=1); [8] lz_blank; [9] blink_en; others read 0.
//   BLINK_DIV RW: writing 0 stores 1. Any write to BLINK_DIV clears cnt and phase to 0 on that edge.
//   STATUS RO: [0]=blink phase; writes ignored.
//  Avalon: no waitrequest; write takes effect at the clk edge where write=1.
//   Read: readdata updated at the edge where read=1, holds until the next read.
//   Read+write same cycle, same addr: readdata returns pre-write value.
//   address 3 write: no effect.
//  Blink counter: increments every cycle; on cnt==BLINK_DIV-1 -> cnt=0, phase toggles.
//   Runs regardless of blink_en.
//  Digit visibility for digit i: en[i] && !(blink_en && phase) && !lz_hidden[i].
//   lz_hidden[i]=1 when lz_blank=1 and all nibbles j>=i are 0, for i>=1; digit 0 never lz-hidden.
//   Hidden digit drives 7'h7F.
//  Decode (active low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//   7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
//  Latency: hex* outputs are registered from current reg state.
//   A write to VALUE/CTRL at edge N is visible on hex* after edge N+1. Phase toggle is visible one edge later.
//  Reset mid-operation: all state returns to reset values on that edge.
//   hex*=7'h7F for the reset cycle; decoded "000000" appears after the first edge with reset=0.
//  No combinational path from Avalon inputs to any output.
// TESTING
//  Reset, then idle 2 cycles -> hex0..5 = 7'b1000000; read addr1 -> 0x03F; read addr2 -> 25_000_000.
//  Write VALUE=0x12AB3F -> after 2 edges hex5..0 = 1,2,A,b,3,F encodings; read addr0 -> 0x0012AB3F.
//  Write CTRL=0x13F, VALUE=0x000040 -> hex0=0, hex1=4 shown; hex2..5=7'h7F.
//   VALUE=0 -> only hex0 shows 0.
//  Write BLINK_DIV=4, CTRL=0x23F -> phase toggles every 4 cycles.
//   hex* alternate blank/digits with 4-cycle half-period; STATUS[0] tracks phase.
//  Write BLINK_DIV=0 -> read back 1; phase toggles every cycle.
//   Simultaneous read+write addr0 returns old VALUE.
//  Assert reset mid-blink with VALUE=0xFFFFFF -> next edge hex*=7'h7F, VALUE=0, CTRL=0x03F, phase=0.

Source files
------------

// File: rtl/hex_display_slave.sv
// hex_display_slave: Avalon-MM register block driving six active-low
// seven-segment displays from a 24-bit value, with per-digit enable,
// leading-zero blanking and a programmable blink.

// Single-digit decoder: hex nibble to active-low segments (bit0 = a .. bit6 = g).
// A hidden digit drives all segments off.
module hex_digit (
    input  logic [3:0] nib_i,
    input  logic       show_i,
    output logic [6:0] seg_o
);

    // Nibble lookup, overridden to blank when the digit is not shown
    always_comb begin
        seg_o = 7'h7F;
        if (show_i) begin
            unique case (nib_i)
                4'h0: seg_o = 7'b1000000;
                4'h1: seg_o = 7'b1111001;
                4'h2: seg_o = 7'b0100100;
                4'h3: seg_o = 7'b0110000;
                4'h4: seg_o = 7'b0011001;
                4'h5: seg_o = 7'b0010010;
                4'h6: seg_o = 7'b0000010;
                4'h7: seg_o = 7'b1111000;
                4'h8: seg_o = 7'b0000000;
                4'h9: seg_o = 7'b0010000;
                4'hA: seg_o = 7'b0001000;
                4'hB: seg_o = 7'b0000011;
                4'hC: seg_o = 7'b1000110;
                4'hD: seg_o = 7'b0100001;
                4'hE: seg_o = 7'b0000110;
                4'hF: seg_o = 7'b0001110;
                default: seg_o = 7'h7F;
            endcase
        end
    end

endmodule

module hex_display_slave #(
    parameter int          CNT_W         = 32,
    parameter int unsigned BLINK_DIV_RST = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int NUM_DIG = 6;

    localparam logic [1:0] A_VALUE  = 2'd0;
    localparam logic [1:0] A_CTRL   = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    // Register state
    logic [23:0]             value_q,    value_d;
    logic [NUM_DIG-1:0]      en_q,       en_d;
    logic                    lz_q,       lz_d;
    logic                    ben_q,      ben_d;
    logic [CNT_W-1:0]        div_q,      div_d;
    logic [CNT_W-1:0]        cnt_q,      cnt_d;
    logic                    phase_q,    phase_d;
    logic [31:0]             rdata_q,    rdata_d;
    logic [NUM_DIG-1:0][6:0] hex_q,      hex_d;

    logic wr_value, wr_ctrl, wr_div;
    logic cnt_wrap;

    assign wr_value = write && (address == A_VALUE);
    assign wr_ctrl  = write && (address == A_CTRL);
    assign wr_div   = write && (address == A_DIV);
    assign cnt_wrap = (cnt_q == (div_q - CNT_W'(1)));

    // Register writes; BLINK_DIV of 0 is stored as 1 so the counter always wraps
    always_comb begin
        value_d = value_q;
        en_d    = en_q;
        lz_d    = lz_q;
        ben_d   = ben_q;
        div_d   = div_q;
        if (wr_value) value_d = writedata[23:0];
        if (wr_ctrl) begin
            en_d  = writedata[NUM_DIG-1:0];
            lz_d  = writedata[8];
            ben_d = writedata[9];
        end
        if (wr_div) begin
            div_d = (writedata[CNT_W-1:0] == '0) ? CNT_W'(1) : writedata[CNT_W-1:0];
        end
    end

    // Free-running blink divider; a BLINK_DIV write restarts it in phase 0
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (wr_div) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_wrap) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Read mux from pre-edge state so a same-cycle write returns the old value
    always_comb begin
        rdata_d = rdata_q;
        if (read) begin
            unique case (address)
                A_VALUE:  rdata_d = {8'h00, value_q};
                A_CTRL:   rdata_d = {22'd0, ben_q, lz_q, 2'b00, en_q};
                A_DIV:    rdata_d = 32'(div_q);
                A_STATUS: rdata_d = {31'd0, phase_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    // Per-digit visibility and decode, all from registered state only
    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        logic lz_hide;
        logic show;
        if (i == 0) begin : g_lz0
            assign lz_hide = 1'b0;
        end else begin : g_lzn
            assign lz_hide = lz_q && (value_q[23:4*i] == '0);
        end
        assign show = en_q[i] && !(ben_q && phase_q) && !lz_hide;
        hex_digit u_dig (
            .nib_i  (value_q[4*i +: 4]),
            .show_i (show),
            .seg_o  (hex_d[i])
        );
    end

    // State update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            en_q    <= '1;
            lz_q    <= 1'b0;
            ben_q   <= 1'b0;
            div_q   <= CNT_W'(BLINK_DIV_RST);
            cnt_q   <= '0;
            phase_q <= 1'b0;
            rdata_q <= '0;
            hex_q   <= {NUM_DIG{7'h7F}};
        end else begin
            value_q <= value_d;
            en_q    <= en_d;
            lz_q    <= lz_d;
            ben_q   <= ben_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            rdata_q <= rdata_d;
            hex_q   <= hex_d;
        end
    end

    assign readdata = rdata_q;
    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];

endmodule

// File: tb/tb_hex_display_slave.sv
// Bench for hex_display_slave: directed scenarios plus randomized Avalon
// traffic, checked every cycle against a behavioural model of the register map.
module tb_hex_display_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    always #5 clk = ~clk;

    hex_display_slave dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .hex4      (hex4),
        .hex5      (hex5)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Segment table straight from the decode list (bit6 = g .. bit0 = a)
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Behavioural model state
    int unsigned m_val, m_ctrl, m_div, m_cnt, m_ph, m_rd;
    logic [6:0]  m_hex [6];

    function automatic logic [6:0] model_digit(input int i);
        int unsigned nib;
        bit vis;
        nib = (m_val >> (4 * i)) & 32'hF;
        vis = ((m_ctrl >> i) & 1) == 1;
        if (((m_ctrl >> 9) & 1) == 1 && m_ph == 1) vis = 0;
        if (((m_ctrl >> 8) & 1) == 1 && i >= 1 && (m_val >> (4 * i)) == 0) vis = 0;
        return vis ? seg_tab[nib] : 7'h7F;
    endfunction

    function automatic logic [6:0] dut_hex(input int i);
        case (i)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            3: return hex3;
            4: return hex4;
            default: return hex5;
        endcase
    endfunction

    // One clock cycle: drive, advance the model on the edge, compare everything
    task automatic cyc(input logic rst, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd);
        logic [6:0] nh [6];
        reset = rst; read = rd; write = wr; address = a; writedata = wd;
        @(posedge clk);
        if (rst) begin
            m_val = 0; m_ctrl = 32'h3F; m_div = 25_000_000; m_cnt = 0; m_ph = 0; m_rd = 0;
            for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
        end else begin
            for (int i = 0; i < 6; i++) nh[i] = model_digit(i);
            if (rd) begin
                case (a)
                    2'd0: m_rd = m_val;
                    2'd1: m_rd = m_ctrl;
                    2'd2: m_rd = m_div;
                    default: m_rd = m_ph;
                endcase
            end
            if (wr && a == 2'd2) begin
                m_cnt = 0; m_ph = 0;
            end else if (m_cnt + 1 == m_div) begin
                m_cnt = 0; m_ph = 1 - m_ph;
            end else begin
                m_cnt++;
            end
            if (wr && a == 2'd0) m_val = wd & 32'h00FF_FFFF;
            if (wr && a == 2'd1) m_ctrl = wd & 32'h0000_033F;
            if (wr && a == 2'd2) m_div = (wd == 0) ? 1 : wd;
            for (int i = 0; i < 6; i++) m_hex[i] = nh[i];
        end
        #1;
        for (int i = 0; i < 6; i++) chk($sformatf("hex%0d", i), 32'(dut_hex(i)), 32'(m_hex[i]));
        chk("readdata", readdata, m_rd);
        reset = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 2'd0, 32'd0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        cyc(0, 0, 1, a, wd);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cyc(0, 1, 0, a, 32'd0);
    endtask

    int unsigned r, wd;
    logic [1:0] ra;

    initial begin
        // Reset and default display
        cyc(1, 0, 0, 2'd0, 32'd0);
        chk("rst_hex0", 32'(hex0), 32'h7F);
        chk("rst_rdata", readdata, 32'd0);
        cyc(1, 0, 0, 2'd0, 32'd0);
        idle(2);
        chk("idle_hex5", 32'(hex5), 32'b1000000);
        rd_reg(2'd1);
        chk("rd_ctrl_rst", readdata, 32'h3F);
        rd_reg(2'd2);
        chk("rd_div_rst", readdata, 32'd25_000_000);

        // Full value decode
        wr_reg(2'd0, 32'hFF12_AB3F);
        idle(1);
        chk("val_hex5", 32'(hex5), 32'b1111001);
        chk("val_hex3", 32'(hex3), 32'b0001000);
        chk("val_hex0", 32'(hex0), 32'b0001110);
        rd_reg(2'd0);
        chk("rd_value", readdata, 32'h0012_AB3F);

        // Leading-zero blanking
        wr_reg(2'd1, 32'h13F);
        wr_reg(2'd0, 32'h40);
        idle(1);
        chk("lz_hex1", 32'(hex1), 32'b0011001);
        chk("lz_hex2", 32'(hex2), 32'h7F);
        wr_reg(2'd0, 32'h0);
        idle(1);
        chk("lz0_hex0", 32'(hex0), 32'b1000000);
        chk("lz0_hex1", 32'(hex1), 32'h7F);

        // Blink with 4-cycle half period
        wr_reg(2'd0, 32'h00_1234);
        wr_reg(2'd2, 32'd4);
        wr_reg(2'd1, 32'h23F);
        for (int k = 0; k < 12; k++) rd_reg(2'd3);

        // BLINK_DIV=0 stores 1 and toggles every cycle
        wr_reg(2'd2, 32'd0);
        rd_reg(2'd2);
        chk("rd_div0", readdata, 32'd1);
        for (int k = 0; k < 6; k++) rd_reg(2'd3);

        // Read+write same address returns old value; status write ignored
        cyc(0, 1, 1, 2'd0, 32'h00AB_CDEF);
        chk("rdw_old", readdata, 32'h0000_1234);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        rd_reg(2'd0);
        chk("rdw_new", readdata, 32'h00AB_CDEF);

        // Reset mid-blink
        wr_reg(2'd0, 32'hFF_FFFF);
        idle(3);
        cyc(1, 0, 0, 2'd0, 32'd0);
        chk("mid_rst_hex4", 32'(hex4), 32'h7F);
        rd_reg(2'd1);
        chk("mid_rst_ctrl", readdata, 32'h3F);
        rd_reg(2'd3);
        rd_reg(2'd0);
        chk("mid_rst_val", readdata, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            r  = $urandom_range(0, 199);
            ra = 2'($urandom_range(0, 3));
            case (ra)
                2'd0: wd = $urandom >> $urandom_range(0, 28);
                2'd2: wd = $urandom_range(0, 6);
                default: wd = $urandom;
            endcase
            cyc(r < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, ra, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
